// File: rtl/mem_rw_bank_arbiter.sv
// mem_rw_bank_arbiter
// Shares one single-ported memory bank between two mem-protocol requesters
// (port 0 = read side, port 1 = write side of a read/write-split converter).
// Round-robin arbitration, request locking until grant, and in-order
// response routing through a FIFO of 1-bit port IDs.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   busy_o                    any slv_req_i high or responses outstanding
//   slv_req_i/slv_gnt_o       per-port request / zero-latency grant
//   slv_addr_i .. slv_we_i    per-port request payload
//   slv_rvalid_o/slv_rdata_o  per-port response (rdata broadcast to both)
//   mem_req_o/mem_gnt_i       bank request handshake
//   mem_addr_o .. mem_we_o    bank request payload (from the selected port)
//   mem_rvalid_i/mem_rdata_i  bank response, one per granted request, in order
//
// Handshake: a request transfers in any cycle where req and gnt are both high.
// A requester holds req and payload stable until it sees gnt; there is no
// ready/back-pressure on the response side, and rvalid is a single-cycle pulse.
module mem_rw_bank_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned StrbWidth     = DataWidth / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      busy_o,
  input  logic [1:0]                slv_req_i,
  output logic [1:0]                slv_gnt_o,
  input  logic [1:0][AddrWidth-1:0] slv_addr_i,
  input  logic [1:0][DataWidth-1:0] slv_wdata_i,
  input  logic [1:0][StrbWidth-1:0] slv_strb_i,
  input  logic [1:0][5:0]           slv_atop_i,
  input  logic [1:0]                slv_we_i,
  output logic [1:0]                slv_rvalid_o,
  output logic [1:0][DataWidth-1:0] slv_rdata_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [StrbWidth-1:0]      mem_strb_o,
  output logic [5:0]                mem_atop_o,
  output logic                      mem_we_o,
  input  logic                      mem_rvalid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  // Arbitration state
  logic                      r_last;      // port granted most recently
  logic                      r_lock;      // a request was offered but not yet granted
  logic                      r_lock_sel;  // port that owns the lock

  // Route FIFO of port IDs for outstanding requests
  logic [MaxOutstanding-1:0] r_fifo;
  logic [PtrW-1:0]           r_wr_ptr;
  logic [PtrW-1:0]           r_rd_ptr;
  logic [CntW-1:0]           r_count;

  logic w_sel;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_full  = (r_count == CntW'(MaxOutstanding));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_push  = mem_req_o & mem_gnt_i;
  // A response with nothing outstanding is dropped rather than routed.
  assign w_pop   = mem_rvalid_i & ~w_empty;

  assign busy_o  = (|slv_req_i) | ~w_empty;

  always_comb begin
    // Locked port keeps the bank until granted; otherwise round-robin on
    // contention, else whichever port is requesting.
    w_sel = slv_req_i[1];
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (&slv_req_i) begin
      w_sel = ~r_last;
    end

    // Fullness uses registered occupancy only, so a same-cycle pop never
    // opens a combinational path from mem_rvalid_i to mem_req_o.
    mem_req_o   = slv_req_i[w_sel] & ~w_full;
    mem_addr_o  = slv_addr_i[w_sel];
    mem_wdata_o = slv_wdata_i[w_sel];
    mem_strb_o  = slv_strb_i[w_sel];
    mem_atop_o  = slv_atop_i[w_sel];
    mem_we_o    = slv_we_i[w_sel];

    slv_gnt_o        = '0;
    slv_gnt_o[w_sel] = mem_req_o & mem_gnt_i;

    slv_rvalid_o         = '0;
    slv_rvalid_o[w_head] = w_pop;
  end

  assign slv_rdata_o[0] = mem_rdata_i;
  assign slv_rdata_o[1] = mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last     <= 1'b1;  // port 0 wins the first contention
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_fifo     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_last <= w_sel;
        r_lock <= 1'b0;
      end else if (mem_req_o) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end

      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Protocol checks
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(r_lock && !slv_req_i[r_lock_sel]))
        else $error("locked port dropped its request before grant");
      assert (!(mem_rvalid_i && w_empty))
        else $warning("mem_rvalid_i with no outstanding request ignored");
    end
  end

endmodule

// File: tb/tb_mem_rw_bank_arbiter.sv
module tb_mem_rw_bank_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int MO = 2;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 busy_o;
  logic [1:0]           slv_req_i;
  logic [1:0]           slv_gnt_o;
  logic [1:0][AW-1:0]   slv_addr_i;
  logic [1:0][DW-1:0]   slv_wdata_i;
  logic [1:0][SW-1:0]   slv_strb_i;
  logic [1:0][5:0]      slv_atop_i;
  logic [1:0]           slv_we_i;
  logic [1:0]           slv_rvalid_o;
  logic [1:0][DW-1:0]   slv_rdata_o;
  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic [AW-1:0]        mem_addr_o;
  logic [DW-1:0]        mem_wdata_o;
  logic [SW-1:0]        mem_strb_o;
  logic [5:0]           mem_atop_o;
  logic                 mem_we_o;
  logic                 mem_rvalid_i;
  logic [DW-1:0]        mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  mem_rw_bank_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .busy_o(busy_o),
    .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o),
    .slv_addr_i(slv_addr_i), .slv_wdata_i(slv_wdata_i),
    .slv_strb_i(slv_strb_i), .slv_atop_i(slv_atop_i), .slv_we_i(slv_we_i),
    .slv_rvalid_o(slv_rvalid_o), .slv_rdata_o(slv_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_atop_o(mem_atop_o),
    .mem_we_o(mem_we_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    slv_req_i    = '0;
    slv_addr_i   = '0;
    slv_wdata_i  = '0;
    slv_strb_i   = '0;
    slv_atop_i   = '0;
    slv_we_i     = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic set_port(input int p, input logic req, input logic [AW-1:0] addr,
                          input logic we);
    slv_req_i[p]   = req;
    slv_addr_i[p]  = addr;
    slv_we_i[p]    = we;
    slv_wdata_i[p] = {addr, ~addr};
    slv_strb_i[p]  = 8'hFF;
    slv_atop_i[p]  = 6'd0;
  endtask

  // Entered and left just after a falling edge.
  task automatic apply_reset();
    drive_idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
    checks++; if (slv_gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", slv_gnt_o); end
    checks++; if (slv_rvalid_o !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", slv_rvalid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (mem_addr_o !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    apply_reset();
    set_port(0, 1'b1, 32'h10, 1'b0);
    mem_gnt_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", mem_req_o); end
    checks++; if (slv_gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", slv_gnt_o); end
    checks++; if (mem_addr_o !== 32'h10) begin failures++; $display("FAIL single_addr got=%h exp=10", mem_addr_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL single_we got=%b exp=0", mem_we_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    @(negedge clk_i);
    rd = {$urandom, $urandom};
    set_port(0, 1'b0, 32'h0, 1'b0);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    #1;
    checks++; if (slv_rvalid_o !== 2'b01) begin failures++; $display("FAIL single_rvalid got=%b exp=01", slv_rvalid_o); end
    checks++; if (slv_rdata_o[0] !== rd) begin failures++; $display("FAIL single_rdata got=%h exp=%h", slv_rdata_o[0], rd); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL single_req_idle got=%b exp=0", mem_req_o); end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy_o); end
    checks++; if (slv_rvalid_o !== 2'b00) begin failures++; $display("FAIL single_rvalid_end got=%b exp=00", slv_rvalid_o); end
    @(negedge clk_i);
  endtask

  task automatic test_alternate();
    logic [1:0]    eg;
    logic [1:0]    erv;
    logic [AW-1:0] ea;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      set_port(0, 1'b1, 32'h1000, 1'b0);
      set_port(1, 1'b1, 32'h2000, 1'b1);
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (c > 0);
      mem_rdata_i  = DW'(c);
      #1;
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      ea = (c % 2 == 0) ? 32'h1000 : 32'h2000;
      checks++; if (slv_gnt_o !== eg) begin failures++; $display("FAIL alt_gnt c=%0d got=%b exp=%b", c, slv_gnt_o, eg); end
      checks++; if (mem_addr_o !== ea) begin failures++; $display("FAIL alt_addr c=%0d got=%h exp=%h", c, mem_addr_o, ea); end
      if (c > 0) begin
        erv = ((c - 1) % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (slv_rvalid_o !== erv) begin failures++; $display("FAIL alt_rvalid c=%0d got=%b exp=%b", c, slv_rvalid_o, erv); end
      end
      @(negedge clk_i);
    end
    drive_idle();
    mem_rvalid_i = 1'b1;
    #1;
    checks++; if (slv_rvalid_o !== 2'b10) begin failures++; $display("FAIL alt_rvalid_last got=%b exp=10", slv_rvalid_o); end
    @(negedge clk_i);
    drive_idle();
  endtask

  task automatic test_lock();
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    apply_reset();
    // Grant port 0 once so plain round-robin would now favour port 1.
    set_port(0, 1'b1, 32'h40, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    drive_idle();
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    drive_idle();
    for (int c = 0; c < 5; c++) begin
      set_port(0, (c < 4), 32'hA0, 1'b0);
      set_port(1, (c >= 1), 32'hB0, 1'b1);
      mem_gnt_i = (c >= 3);
      #1;
      eg = (c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      ea = (c < 4) ? 32'hA0 : 32'hB0;
      checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL lock_req c=%0d got=%b exp=1", c, mem_req_o); end
      checks++; if (slv_gnt_o !== eg) begin failures++; $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, slv_gnt_o, eg); end
      checks++; if (mem_addr_o !== ea) begin failures++; $display("FAIL lock_addr c=%0d got=%h exp=%h", c, mem_addr_o, ea); end
      checks++; if (mem_we_o !== (c == 4)) begin failures++; $display("FAIL lock_we c=%0d got=%b exp=%b", c, mem_we_o, (c == 4)); end
      @(negedge clk_i);
    end
    drive_idle();
  endtask

  task automatic test_fifo_full();
    logic [4:0]    rvv;
    logic [4:0]    ereq;
    logic [1:0]    erv;
    logic [AW-1:0] a;
    rvv  = 5'b01000;
    ereq = 5'b10011;
    a    = 32'h300;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_port(0, 1'b1, a, 1'b0);
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = rvv[c];
      mem_rdata_i  = {$urandom, $urandom};
      #1;
      erv = rvv[c] ? 2'b01 : 2'b00;
      checks++; if (mem_req_o !== ereq[c]) begin failures++; $display("FAIL full_req c=%0d got=%b exp=%b", c, mem_req_o, ereq[c]); end
      checks++; if (slv_gnt_o !== {1'b0, ereq[c]}) begin failures++; $display("FAIL full_gnt c=%0d got=%b exp=%b", c, slv_gnt_o, {1'b0, ereq[c]}); end
      checks++; if (slv_rvalid_o !== erv) begin failures++; $display("FAIL full_rvalid c=%0d got=%b exp=%b", c, slv_rvalid_o, erv); end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL full_busy c=%0d got=%b exp=1", c, busy_o); end
      if (ereq[c]) begin
        checks++; if (mem_addr_o !== a) begin failures++; $display("FAIL full_addr c=%0d got=%h exp=%h", c, mem_addr_o, a); end
        a = a + 32'd8;
      end
      @(negedge clk_i);
    end
    drive_idle();
  endtask

  task automatic test_in_order();
    logic [4:0]    p0r, p1r, rvv, g0, g1, rv0, rv1;
    logic [DW-1:0] d;
    p0r = 5'b01101; p1r = 5'b00010; rvv = 5'b11100;
    g0  = 5'b01001; g1  = 5'b00010;
    rv0 = 5'b10100; rv1 = 5'b01000;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_port(0, p0r[c], (c < 2) ? 32'h500 : 32'h508, 1'b0);
      set_port(1, p1r[c], 32'h600, 1'b1);
      mem_gnt_i    = 1'b1;
      d            = {$urandom, $urandom};
      mem_rvalid_i = rvv[c];
      mem_rdata_i  = d;
      #1;
      checks++; if (slv_gnt_o !== {g1[c], g0[c]}) begin failures++; $display("FAIL order_gnt c=%0d got=%b exp=%b", c, slv_gnt_o, {g1[c], g0[c]}); end
      checks++; if (slv_rvalid_o !== {rv1[c], rv0[c]}) begin failures++; $display("FAIL order_rvalid c=%0d got=%b exp=%b", c, slv_rvalid_o, {rv1[c], rv0[c]}); end
      if (rvv[c]) begin
        checks++; if (slv_rdata_o[rv1[c]] !== d) begin failures++; $display("FAIL order_rdata c=%0d got=%h exp=%h", c, slv_rdata_o[rv1[c]], d); end
      end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL order_busy c=%0d got=%b exp=1", c, busy_o); end
      @(negedge clk_i);
    end
    drive_idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL order_busy_end got=%b exp=0", busy_o); end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_port(0, 1'b1, 32'h700, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    set_port(0, 1'b0, 32'h0, 1'b0);
    set_port(1, 1'b1, 32'h780, 1'b1);
    @(negedge clk_i);
    drive_idle();
    #1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", mem_req_o); end
    // Stray response while everything is cleared must not be routed.
    mem_rvalid_i = 1'b1;
    #1;
    checks++; if (slv_rvalid_o !== 2'b00) begin failures++; $display("FAIL rstmid_stray_rvalid got=%b exp=00", slv_rvalid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_stray_busy got=%b exp=0", busy_o); end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    // After reset port 0 wins the first contention again.
    set_port(0, 1'b1, 32'h800, 1'b0);
    set_port(1, 1'b1, 32'h880, 1'b1);
    mem_gnt_i = 1'b1;
    #1;
    checks++; if (slv_gnt_o !== 2'b01) begin failures++; $display("FAIL rstmid_first_gnt got=%b exp=01", slv_gnt_o); end
    @(negedge clk_i);
    drive_idle();
  endtask

  // ---------------- randomized test with reference model ----------------
  task automatic test_random();
    logic          pend_v   [2];
    logic [AW-1:0] pend_addr[2];
    logic [DW-1:0] pend_wd  [2];
    logic [SW-1:0] pend_strb[2];
    logic [5:0]    pend_atop[2];
    logic          pend_we  [2];
    logic [0:0]    id_q[$];
    logic [DW-1:0] bank_q[$];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] d, ed;
    logic [110:0]  got_pl, exp_pl;
    logic [1:0]    eg, erv;
    logic          m_last, m_locked, m_lock_port;
    logic          w, ereq, rv, ebusy;
    int            p_new;

    apply_reset();
    m_last = 1'b1; m_locked = 1'b0; m_lock_port = 1'b0;
    for (int p = 0; p < 2; p++) pend_v[p] = 1'b0;
    p_new = 40;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1700) p_new = 0;
      for (int p = 0; p < 2; p++) begin
        if (!pend_v[p] && $urandom_range(0, 99) < p_new) begin
          pend_v[p]    = 1'b1;
          pend_addr[p] = $urandom;
          pend_wd[p]   = {$urandom, $urandom};
          pend_strb[p] = SW'($urandom);
          pend_atop[p] = 6'($urandom);
          pend_we[p]   = (p == 1);
        end
        slv_req_i[p]   = pend_v[p];
        slv_addr_i[p]  = pend_addr[p];
        slv_wdata_i[p] = pend_wd[p];
        slv_strb_i[p]  = pend_strb[p];
        slv_atop_i[p]  = pend_atop[p];
        slv_we_i[p]    = pend_we[p];
      end
      mem_gnt_i    = ($urandom_range(0, 99) < 65);
      rv           = (bank_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rvalid_i = rv;
      mem_rdata_i  = rv ? bank_q[0] : {$urandom, $urandom};
      #1;

      // Who should own the bank this cycle.
      if (m_locked)                  w = m_lock_port;
      else if (pend_v[0] && pend_v[1]) w = ~m_last;
      else                           w = pend_v[1];
      ereq  = pend_v[w] && (id_q.size() < MO);
      eg    = (ereq && mem_gnt_i) ? (w ? 2'b10 : 2'b01) : 2'b00;
      erv   = rv ? (id_q[0] ? 2'b10 : 2'b01) : 2'b00;
      ebusy = pend_v[0] || pend_v[1] || (id_q.size() != 0);

      checks++; if (mem_req_o !== ereq) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mem_req_o, ereq); end
      checks++; if (slv_gnt_o !== eg) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, slv_gnt_o, eg); end
      checks++; if (slv_rvalid_o !== erv) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, slv_rvalid_o, erv); end
      checks++; if (busy_o !== ebusy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, ebusy); end
      if (ereq) begin
        got_pl = {mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o};
        exp_pl = {pend_addr[w], pend_wd[w], pend_strb[w], pend_atop[w], pend_we[w]};
        checks++; if (got_pl !== exp_pl) begin failures++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, got_pl, exp_pl); end
      end
      if (rv) begin
        ed = id_q[0] ? exp_q1.pop_front() : exp_q0.pop_front();
        checks++; if (slv_rdata_o[id_q[0]] !== ed) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, slv_rdata_o[id_q[0]], ed); end
        void'(id_q.pop_front());
        void'(bank_q.pop_front());
      end

      if (ereq && mem_gnt_i) begin
        d = {$urandom, $urandom};
        id_q.push_back(w);
        bank_q.push_back(d);
        if (w) exp_q1.push_back(d); else exp_q0.push_back(d);
        m_last    = w;
        m_locked  = 1'b0;
        pend_v[w] = 1'b0;
      end else if (ereq) begin
        m_locked    = 1'b1;
        m_lock_port = w;
      end
      @(negedge clk_i);
    end

    checks++;
    if (pend_v[0] || pend_v[1] || id_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain pending=%b%b outstanding=%0d exp=0", pend_v[1], pend_v[0], id_q.size());
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_ni = 1'b0;
    drive_idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_fifo_full();
    test_in_order();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
